bram_stream_reader: RTL

Read-side streaming stage for the dual-port BRAM. On a start command it walks a contiguous address range through one BRAM read port (read-enable, address, read-ack, data), buffers the returned words in a 4-entry FIFO, and presents them as an AXI-Stream master with full backpressure and `tlast` on the final word. It sits directly downstream of the BRAM and feeds the compute datapath.

---
 rtl/bram_stream_reader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// Streams a contiguous BRAM address range out as an AXI-Stream master.
// Reads are credit-gated so returned words always fit in the output FIFO.
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_rden,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    input  logic                  bram_rack,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rden_q, rden_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         issued_q, issued_d;
    logic [LW-1:0]         beat_q, beat_d;
    logic [CW-1:0]         outs_q, outs_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic push, pop, issue, credit_ok, last_beat;

    // Acks arriving while idle belong to a command aborted by reset.
    assign push      = bram_rack && (state_q != IDLE);
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign credit_ok = ({1'b0, count_q} + {1'b0, outs_q}) < (CW+1)'(FIFO_DEPTH);
    assign last_beat = (beat_q == len_q - LW'(1));

    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bram_rden     = rden_q;
    assign bram_addr     = addr_q;
    assign dbg_state     = state_q;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        issue    = 1'b0;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        beat_d   = beat_q;
        if (pop) begin
            beat_d = beat_q + LW'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First read goes out on the accept edge for 3-cycle latency.
                        len_d    = length;
                        addr_d   = base_addr;
                        issued_d = LW'(1);
                        beat_d   = '0;
                        issue    = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = (length == LW'(1)) ? DRAIN : READ;
                    end
                end
            end
            READ: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + LW'(1);
                    if (issued_q + LW'(1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last_beat && (outs_q == '0)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rden_d = issue;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = bram_dout;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        outs_d  = outs_q + CW'(issue) - CW'(push && (outs_q != '0));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rden_q   <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            beat_q   <= '0;
            outs_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rden_q   <= rden_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            beat_q   <= beat_d;
            outs_q   <= outs_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule
